// File: rtl/ysq_seq.sv
// Sequencing controller for the y-square datapath: accepts one operand, squares it
// with a W-cycle shift-add loop, then streams the 2W-bit result as two W-bit beats.
module ysq_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT_LO,
        OUT_HI
    } state_t;

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] addend;
    logic [2*W-1:0] acc_next;
    logic [CW-1:0]  cnt;

    // Partial product for the current multiplier bit; the final sum fits in 2W bits.
    always_comb begin
        addend = '0;
        if (mplier[cnt]) begin
            addend = {{W{1'b0}}, mcand} << cnt;
        end
        acc_next = acc + addend;
    end

    assign in_ready = ena && (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= in_data;
                        mplier <= in_data;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // Low beat is loaded from the final sum so it is valid on OUT_LO entry.
                    if (cnt == CW'(W - 1)) begin
                        state     <= OUT_LO;
                        out_valid <= 1'b1;
                        out_data  <= acc_next[W-1:0];
                        out_last  <= 1'b0;
                    end
                end
                OUT_LO: begin
                    if (out_ready) begin
                        state    <= OUT_HI;
                        out_data <= acc[2*W-1:W];
                        out_last <= 1'b1;
                    end
                end
                OUT_HI: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysq_seq.sv
// Directed self-checking bench for ysq_seq (W=8): corners, backpressure, stall, reset.
module tb_ysq_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    ysq_seq #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] x);
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Advances until out_valid is seen at a negedge, counting edges (bounded).
    task automatic wait_valid(inout int lat);
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        ena = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h busy=%b ready=%b, need 0 00 0 1",
                     out_valid, out_data, busy, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'h05;
        repeat (3) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_accept: busy=%b valid=%b, need 0 0", busy, out_valid);
            end
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b valid=%b ready=%b, need 0 0 1", busy, out_valid, in_ready);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] xs [3] = '{8'd0, 8'd255, 8'd13};
        logic [W-1:0] lo [3] = '{8'h00, 8'h01, 8'hA9};
        logic [W-1:0] hi [3] = '{8'h00, 8'hFE, 8'h00};
        int lat;
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            start_op(xs[i]);
            lat = 1;
            wait_valid(lat);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL corner_latency x=%0d: got %0d, need 9", xs[i], lat);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== lo[i] || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL corner_lo x=%0d: valid=%b data=%h last=%b, need 1 %h 0",
                         xs[i], out_valid, out_data, out_last, lo[i]);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== hi[i] || out_last !== 1'b1) begin
                n_fail++;
                $display("FAIL corner_hi x=%0d: valid=%b data=%h last=%b, need 1 %h 1",
                         xs[i], out_valid, out_data, out_last, hi[i]);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL corner_done x=%0d: valid=%b data=%h ready=%b busy=%b, need 0 00 1 0",
                         xs[i], out_valid, out_data, in_ready, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(8'd200);
        lat = 1;
        wait_valid(lat);
        out_ready = 1'b0;
        repeat (5) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h40 || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b data=%h last=%b, need 1 40 0", out_valid, out_data, out_last);
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h9C || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hi: valid=%b data=%h last=%b, need 1 9c 1", out_valid, out_data, out_last);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: valid=%b ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        start_op(8'd3);
        lat = 1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (2) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_valid(lat);
        n_checks++;
        if (lat !== 9 || out_data !== 8'h09 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_lo: lat=%0d data=%h last=%b, need 9 09 0", lat, out_data, out_last);
        end
        step();
        n_checks++;
        if (out_data !== 8'h00 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_hi: data=%h last=%b, need 00 1", out_data, out_last);
        end
        repeat (12) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_no_second: valid=%b busy=%b, need 0 0", out_valid, busy);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        start_op(8'd17);
        lat = 1;
        repeat (3) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ena = 1'b0;
        repeat (4) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
                n_fail++;
                $display("FAIL stall_calc: busy=%b ready=%b valid=%b data=%h, need 1 0 0 00",
                         busy, in_ready, out_valid, out_data);
            end
        end
        ena = 1'b1;
        wait_valid(lat);
        n_checks++;
        if (lat !== 13 || out_data !== 8'h21 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_lo: lat=%0d data=%h last=%b, need 13 21 0", lat, out_data, out_last);
        end
        ena = 1'b0;
        repeat (2) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h21 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_out: valid=%b data=%h last=%b ready=%b, need 1 21 0 0",
                         out_valid, out_data, out_last, in_ready);
            end
        end
        ena = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hi: valid=%b data=%h last=%b, need 1 01 1", out_valid, out_data, out_last);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(8'd255);
        lat = 1;
        wait_valid(lat);
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b busy=%b data=%h last=%b ready=%b, need 0 0 00 0 1",
                     out_valid, busy, out_data, out_last, in_ready);
        end
        rst = 1'b0;
        start_op(8'd2);
        lat = 1;
        wait_valid(lat);
        n_checks++;
        if (lat !== 9 || out_data !== 8'h04 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after_lo: lat=%0d data=%h last=%b, need 9 04 0", lat, out_data, out_last);
        end
        step();
        n_checks++;
        if (out_data !== 8'h00 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after_hi: data=%h last=%b, need 00 1", out_data, out_last);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int e;
        in_data  = 8'd13;
        in_valid = 1'b1;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        n_checks++;
        if (e + 1 !== W + 3) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d, need %0d", e + 1, W + 3);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_reaccept: busy=%b, need 1", busy);
        end
        repeat (W + 3) step();
    endtask

    initial begin
        test_reset();
        test_corners();
        test_backpressure();
        test_ignore_busy();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
